// File: rtl/shift_arbiter_pkg.sv
// rtl/shift_arbiter_pkg.sv - shared ALU constants for the shifter arbiter
package shift_arbiter_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_AMT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/shift_arbiter_rr_arbiter2.sv
// rtl/shift_arbiter_rr_arbiter2.sv - two-way round-robin grant from valids and last winner
module rr_arbiter2
  import shift_arbiter_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant0,
  output logic grant1
);

  // On a tie the requester that did not win last time is chosen.
  assign grant0 = valid0 && (!valid1 || last_grant);
  assign grant1 = valid1 && (!valid0 || !last_grant);

endmodule

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - shares one combinational barrel shifter between two requesters
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int AMT_W = DEFAULT_AMT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [AMT_W-1:0] req0_amt,
  input  logic             req0_dir,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [AMT_W-1:0] req1_amt,
  input  logic             req1_dir,
  output logic [WIDTH-1:0] sh_a,
  output logic [AMT_W-1:0] sh_amt,
  output logic             sh_dir,
  input  logic [WIDTH-1:0] sh_y,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_y,
  output logic             busy
);

  state_t           state, state_nxt;
  logic             grant0, grant1;
  logic             last_grant;
  logic [WIDTH-1:0] op_a;
  logic [AMT_W-1:0] op_amt;
  logic             op_dir;
  logic             op_id;

  rr_arbiter2 u_arb (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant),
    .grant0     (grant0),
    .grant1     (grant1)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
        if (grant0 || grant1) state_nxt = EXEC;
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_valid && rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The shifter only ever sees registered operands so request inputs never reach it combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_a       <= '0;
      op_amt     <= '0;
      op_dir     <= DIR_RIGHT;
      op_id      <= 1'b0;
      last_grant <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_y      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0) begin
            op_a   <= req0_a;
            op_amt <= req0_amt;
            op_dir <= req0_dir;
            op_id  <= 1'b0;
          end else if (grant1) begin
            op_a   <= req1_a;
            op_amt <= req1_amt;
            op_dir <= req1_dir;
            op_id  <= 1'b1;
          end
        end
        EXEC: begin
          rsp_y     <= sh_y;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid  <= 1'b0;
            last_grant <= op_id;
          end
        end
        default: rsp_valid <= 1'b0;
      endcase
    end
  end

  assign sh_a   = op_a;
  assign sh_amt = op_amt;
  assign sh_dir = op_dir;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - directed self-checking bench for shift_arbiter
module tb_shift_arbiter;
  import shift_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req0_dir;
  logic [31:0] req0_a;
  logic [4:0]  req0_amt;
  logic        req1_valid, req1_ready, req1_dir;
  logic [31:0] req1_a;
  logic [4:0]  req1_amt;
  logic [31:0] sh_a, sh_y, rsp_y;
  logic [4:0]  sh_amt;
  logic        sh_dir, rsp_valid, rsp_ready, rsp_id, busy;

  int vectors = 0;
  int miscompares = 0;

  shift_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_amt(req0_amt), .req0_dir(req0_dir),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_amt(req1_amt), .req1_dir(req1_dir),
    .sh_a(sh_a), .sh_amt(sh_amt), .sh_dir(sh_dir), .sh_y(sh_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_y(rsp_y), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared shifter that sits beside the arbiter in the ALU.
  assign sh_y = (sh_dir == DIR_LEFT) ? (sh_a << sh_amt) : (sh_a >> sh_amt);

  task automatic do_reset;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    reset = 1;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic issue(input logic id, input logic [31:0] a, input logic [4:0] amt,
                       input logic dir, output logic ok);
    ok = 0;
    if (id == 1'b0) begin req0_a = a; req0_amt = amt; req0_dir = dir; req0_valid = 1; end
    else            begin req1_a = a; req1_amt = amt; req1_dir = dir; req1_valid = 1; end
    for (int i = 0; i < 8 && !ok; i++) begin
      #1;
      if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready)) begin
        ok = 1;
        @(posedge clk);
      end
      @(negedge clk);
    end
    if (id == 1'b0) req0_valid = 0; else req1_valid = 0;
  endtask

  task automatic wait_rsp(output logic got, output int edges);
    got = 0; edges = 0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(posedge clk); edges++;
      @(negedge clk); got = rsp_valid;
    end
  endtask

  task automatic ack;
    rsp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 0;
  endtask

  task automatic test_reset;
    reset = 1; rsp_ready = 0;
    req0_valid = 0; req0_a = 0; req0_amt = 0; req0_dir = 0;
    req1_valid = 0; req1_a = 0; req1_amt = 0; req1_dir = 0;
    repeat (2) @(negedge clk);
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b exp 0", busy); end
    vectors++; if (rsp_id !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_id got %b exp 0", rsp_id); end
    vectors++; if (rsp_y !== 32'h0) begin miscompares++; $display("FAIL rst_rsp_y got %h exp 0", rsp_y); end
    vectors++; if ({sh_a, sh_amt, sh_dir} !== 38'h0) begin miscompares++; $display("FAIL rst_sh_ops got %h exp 0", {sh_a, sh_amt, sh_dir}); end
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_req0_left;
    logic ok, got; int e;
    issue(1'b0, 32'h99, 5'd1, DIR_LEFT, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL r0_accept got %b exp 1", ok); end
    vectors++; if (busy !== 1'b1 || req0_ready !== 1'b0) begin miscompares++; $display("FAIL r0_exec busy/ready got %b%b exp 10", busy, req0_ready); end
    vectors++; if ({sh_a, sh_amt, sh_dir} !== {32'h99, 5'd1, 1'b1}) begin miscompares++; $display("FAIL r0_sh_ops got %h exp %h", {sh_a, sh_amt, sh_dir}, {32'h99, 5'd1, 1'b1}); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL r0_early_valid got %b exp 0", rsp_valid); end
    wait_rsp(got, e);
    vectors++; if (got !== 1'b1 || e != 1) begin miscompares++; $display("FAIL r0_latency got %b/%0d exp 1/1", got, e); end
    vectors++; if (rsp_y !== 32'h132) begin miscompares++; $display("FAIL r0_y got %h exp 00000132", rsp_y); end
    vectors++; if (rsp_id !== 1'b0) begin miscompares++; $display("FAIL r0_id got %b exp 0", rsp_id); end
    ack;
    vectors++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL r0_done valid/busy got %b%b exp 00", rsp_valid, busy); end
  endtask

  task automatic test_req1;
    logic ok, got; int e;
    issue(1'b1, 32'h99, 5'd4, DIR_RIGHT, ok);
    wait_rsp(got, e);
    vectors++; if (got !== 1'b1 || rsp_y !== 32'h9) begin miscompares++; $display("FAIL r1_right got %b/%h exp 1/00000009", got, rsp_y); end
    vectors++; if (rsp_id !== 1'b1) begin miscompares++; $display("FAIL r1_right_id got %b exp 1", rsp_id); end
    ack;
    issue(1'b1, 32'h99, 5'd4, DIR_LEFT, ok);
    wait_rsp(got, e);
    vectors++; if (got !== 1'b1 || rsp_y !== 32'h990) begin miscompares++; $display("FAIL r1_left got %b/%h exp 1/00000990", got, rsp_y); end
    vectors++; if (rsp_id !== 1'b1) begin miscompares++; $display("FAIL r1_left_id got %b exp 1", rsp_id); end
    ack;
  endtask

  task automatic test_alternate;
    int ng, nr; logic [2:0] g; logic [31:0] ry [2]; logic rid [2]; logic both;
    ng = 0; nr = 0; g = '0; both = 0;
    ry[0] = '0; ry[1] = '0; rid[0] = 0; rid[1] = 0;
    do_reset;
    req0_a = 32'h99; req0_amt = 5'd0; req0_dir = DIR_LEFT; req0_valid = 1;
    req1_a = 32'h99; req1_amt = 5'd7; req1_dir = DIR_LEFT; req1_valid = 1;
    rsp_ready = 1;
    for (int c = 0; c < 30 && (ng < 3 || nr < 2); c++) begin
      #1;
      if (req0_ready && req1_ready) both = 1;
      if (ng < 3 && (req0_ready || req1_ready)) begin g[ng] = req1_ready; ng++; end
      if (nr < 2 && rsp_valid) begin ry[nr] = rsp_y; rid[nr] = rsp_id; nr++; end
      @(negedge clk);
    end
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    vectors++; if (ng != 3 || g !== 3'b010) begin miscompares++; $display("FAIL alt_grants got %0d/%b exp 3/010", ng, g); end
    vectors++; if (both !== 1'b0) begin miscompares++; $display("FAIL alt_two_ready got %b exp 0", both); end
    vectors++; if (nr != 2 || ry[0] !== 32'h99 || rid[0] !== 1'b0) begin miscompares++; $display("FAIL alt_rsp0 got %0d/%h/%b exp 2/00000099/0", nr, ry[0], rid[0]); end
    vectors++; if (ry[1] !== 32'h4C80 || rid[1] !== 1'b1) begin miscompares++; $display("FAIL alt_rsp1 got %h/%b exp 00004c80/1", ry[1], rid[1]); end
  endtask

  task automatic test_hold_and_edges;
    logic ok, got; int e;
    do_reset;
    req1_a = 32'h80000001; req1_amt = 5'd31; req1_dir = DIR_RIGHT; req1_valid = 1;
    issue(1'b0, 32'h80000001, 5'd31, DIR_LEFT, ok);
    wait_rsp(got, e);
    vectors++; if (got !== 1'b1 || rsp_y !== 32'h80000000) begin miscompares++; $display("FAIL amt31_left got %b/%h exp 1/80000000", got, rsp_y); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); @(negedge clk);
      vectors++; if ({rsp_valid, rsp_id, rsp_y} !== {1'b1, 1'b0, 32'h80000000}) begin miscompares++; $display("FAIL hold_rsp cyc %0d got %b%b/%h exp 10/80000000", c, rsp_valid, rsp_id, rsp_y); end
      vectors++; if ({busy, req0_ready, req1_ready} !== 3'b100) begin miscompares++; $display("FAIL hold_ctl cyc %0d got %b exp 100", c, {busy, req0_ready, req1_ready}); end
    end
    ack;
    issue(1'b1, 32'h80000001, 5'd31, DIR_RIGHT, ok);
    wait_rsp(got, e);
    vectors++; if (got !== 1'b1 || rsp_y !== 32'h1 || rsp_id !== 1'b1) begin miscompares++; $display("FAIL amt31_right got %b/%h/%b exp 1/00000001/1", got, rsp_y, rsp_id); end
    ack;
  endtask

  task automatic test_reset_midop;
    logic ok, got; int e;
    do_reset;
    issue(1'b0, 32'h99, 5'd1, DIR_LEFT, ok);
    wait_rsp(got, e);
    ack;
    issue(1'b1, 32'h99, 5'd2, DIR_LEFT, ok);
    reset = 1;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL exec_rst_busy got %b exp 0", busy); end
    @(negedge clk);
    vectors++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL exec_rst_state got %b%b exp 00", rsp_valid, busy); end
    reset = 0;
    issue(1'b1, 32'h99, 5'd2, DIR_LEFT, ok);
    wait_rsp(got, e);
    reset = 1;
    #1;
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL resp_rst_async got %b exp 0", rsp_valid); end
    @(negedge clk);
    reset = 0;
    req0_valid = 1; req1_valid = 1;
    #1;
    vectors++; if ({req0_ready, req1_ready} !== 2'b10) begin miscompares++; $display("FAIL rst_tie_grant got %b exp 10", {req0_ready, req1_ready}); end
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_req0_left;
    test_req1;
    test_alternate;
    test_hold_and_edges;
    test_reset_midop;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, exp finish before 200000");
    $fatal(1);
  end

endmodule
